// File: rtl/spi_frame_rx.sv
// spi_frame_rx -- SPI (mode 0) frame receiver with clock-domain synchronizers.
//
// This block samples sck, mosi and cs from an external SPI master that is
// asynchronous to clk_in. It assembles MSB-first frames of FRAME_BITS bits.
// A frame is accepted only if exactly FRAME_BITS sck rising edges were seen
// between the cs fall and the cs rise. Any other count is rejected.
//
// Parameters
//   FRAME_BITS  : bits per frame (>= 2)
//   SYNC_STAGES : synchronizer depth applied identically to sck, mosi and cs
//
// Ports
//   clk_in      : system clock, rising edge
//   rst         : synchronous, active-high reset
//   sck         : SPI serial clock (idles low)
//   mosi        : SPI serial data, MSB first
//   cs          : SPI chip select, active-low
//   data_out    : last accepted frame word
//   data_valid  : one-cycle pulse, new frame accepted
//   frame_err   : one-cycle pulse, frame rejected (wrong bit count)
//   busy        : high while a frame is being received (SHIFT and END)
//   frame_count : accepted-frame counter, wraps modulo 256
module spi_frame_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  cs,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy,
  output logic [7:0]            frame_count
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;
  localparam logic [1:0] END       = 2'd3;

  // Bit counter increment that sticks at FRAME_BITS+1. Long frames then
  // remain distinguishable from good ones, and the counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_hist;
  logic                   cs_hist;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   cs_s;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // ---- synchronizer chains + history flops ----
  // cs resets to 1 (deasserted) so that reset itself never creates an edge.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_hist  <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sck_sync[0]  <= sck;
      mosi_sync[0] <= mosi;
      cs_sync[0]   <= cs;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
      end
      sck_hist <= sck_s;
      cs_hist  <= cs_s;
    end
  end

  // ---- stage p0: registered edge strobes, mosi kept in step with sck ----
  logic sck_rise_p0;
  logic cs_rise_p0;
  logic cs_fall_p0;
  logic cs_lvl_p0;
  logic mosi_p0;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sck_rise_p0 <= 1'b0;
      cs_rise_p0  <= 1'b0;
      cs_fall_p0  <= 1'b0;
      cs_lvl_p0   <= 1'b1;
      mosi_p0     <= 1'b0;
    end else begin
      sck_rise_p0 <= sck_s & ~sck_hist;
      cs_rise_p0  <= cs_s & ~cs_hist;
      cs_fall_p0  <= ~cs_s & cs_hist;
      cs_lvl_p0   <= cs_s;
      mosi_p0     <= mosi_s;
    end
  end

  // After reset, the chains still hold reset values rather than real samples.
  // A cs level seen then is not trusted until a real sample reaches stage p0.
  // Otherwise a reset issued while cs stays low would look like "cs high",
  // and the remaining bits of the aborted frame would be received.
  logic [SYNC_STAGES+1:0] warm;
  logic                   warm_done;

  assign warm_done = warm[SYNC_STAGES+1];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      warm <= '0;
    end else begin
      warm <= {warm[SYNC_STAGES:0], 1'b1};
    end
  end

  // ---- stage p1: frame state machine, shift register, outputs ----
  logic [1:0]            state;
  logic [FRAME_BITS-1:0] shift;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= WAIT_IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (warm_done && cs_lvl_p0) state <= IDLE;
        end
        IDLE: begin
          if (cs_fall_p0) begin
            state   <= SHIFT;
            shift   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // If the last sck edge and the cs rise land in the same cycle,
          // the bit is still taken. END then sees the updated count.
          if (sck_rise_p0) begin
            shift   <= {shift[FRAME_BITS-2:0], mosi_p0};
            bit_cnt <= sat_inc(bit_cnt);
          end
          if (cs_rise_p0) state <= END;
        end
        END: begin
          if (bit_cnt == CNT_FULL) begin
            data_out    <= shift;
            data_valid  <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT) || (state == END);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Testbench for spi_frame_rx: randomized SPI frames are checked against a
// frame-level reference model. The model knows only "a frame of n bits
// carrying value v". An accepted frame must have n == FRAME_BITS. An accepted
// frame updates the word and the counter. Any other frame raises an error pulse.
module tb_spi_frame_rx;

  localparam int FB = 16;
  localparam int SS = 2;
  localparam int LAT = SS + 2;  // pulse edge counted from the edge sampling cs high

  logic          clk_in = 1'b0;
  logic          rst;
  logic          sck;
  logic          mosi;
  logic          cs;
  logic [FB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
  logic [7:0]    frame_count;

  spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sck         (sck),
    .mosi        (mosi),
    .cs          (cs),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse monitor: each one-cycle pulse is seen at exactly one falling edge.
  int v_seen = 0;
  int e_seen = 0;
  always @(negedge clk_in) begin
    if (data_valid) v_seen++;
    if (frame_err)  e_seen++;
    if (data_valid && frame_err) check("pulse_overlap", 1, 0);
  end

  // Reference model
  logic [FB-1:0] m_data;
  logic [7:0]    m_count;
  int            m_valid;
  int            m_err;

  task automatic model_reset();
    m_data  = '0;
    m_count = '0;
  endtask

  task automatic model_frame(input logic [31:0] val, input int n);
    if (n == FB) begin
      m_data  = val[FB-1:0];
      m_count = m_count + 8'd1;
      m_valid++;
    end else begin
      m_err++;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_in);
    rst = 1'b1;
    repeat (cycles) @(negedge clk_in);
    rst = 1'b0;
    model_reset();
  endtask

  // MSB-first, sck = clk_in/8. mosi changes while sck is low.
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      repeat (4) @(negedge clk_in);
      sck = 1'b1;
      repeat (4) @(negedge clk_in);
      sck = 1'b0;
    end
  endtask

  // Called with cs just raised at a falling edge. kind: 0 none, 1 valid, 2 error.
  task automatic check_outcome(input string tag, input int kind);
    int first;
    int npulse;
    logic busy_end;
    logic busy_after;
    first = -1;
    npulse = 0;
    busy_end = 1'b0;
    busy_after = 1'b1;
    @(posedge clk_in);  // first edge that samples cs high
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_in);
      #1;
      if (data_valid || frame_err) begin
        npulse++;
        if (first < 0) first = k;
      end
      if (k == LAT - 1) busy_end = busy;
      if (k == LAT) busy_after = busy;
    end
    check({tag, "_npulse"}, npulse, (kind == 0) ? 0 : 1);
    if (kind != 0) begin
      check({tag, "_latency"}, first, LAT);
      check({tag, "_busy_in_end"}, busy_end, 1);
      check({tag, "_busy_after"}, busy_after, 0);
    end
    check({tag, "_valid_cnt"}, v_seen, m_valid);
    check({tag, "_err_cnt"}, e_seen, m_err);
    check({tag, "_data_out"}, data_out, m_data);
    check({tag, "_frame_count"}, frame_count, m_count);
  endtask

  task automatic frame(input string tag, input logic [31:0] val, input int n);
    @(negedge clk_in);
    cs = 1'b0;
    repeat (4) @(negedge clk_in);
    send_bits(val, n);
    repeat (4) @(negedge clk_in);
    cs = 1'b1;
    model_frame(val, n);
    check_outcome(tag, (n == FB) ? 1 : 2);
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cs = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    m_valid = 0;
    m_err = 0;
    model_reset();

    // Reset state
    do_reset(3);
    repeat (10) @(negedge clk_in);
    check("rst_data_out", data_out, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_busy", busy, 0);
    check("rst_valid_cnt", v_seen, 0);
    check("rst_err_cnt", e_seen, 0);

    // Good, short, long frames
    frame("good_a5c3", 32'hA5C3, 16);
    frame("short15", 32'h1FFF, 15);
    frame("long17", 32'h1ABCD, 17);

    // Empty frame: cs low 10 cycles, no sck
    @(negedge clk_in);
    cs = 1'b0;
    repeat (6) @(negedge clk_in);
    check("empty_busy_mid", busy, 1);
    repeat (4) @(negedge clk_in);
    cs = 1'b1;
    model_frame(32'h0, 0);
    check_outcome("empty", 2);
    repeat (4) @(negedge clk_in);

    // Randomized mix of good and bad lengths
    for (int r = 0; r < 24; r++) begin
      int n;
      logic [31:0] v;
      v = $urandom;
      n = ($urandom_range(0, 9) < 6) ? FB : int'($urandom_range(0, 20));
      frame("rand", v, n);
    end

    // Reset in the middle of a frame
    @(negedge clk_in);
    cs = 1'b0;
    repeat (4) @(negedge clk_in);
    send_bits(32'hC3, 8);
    do_reset(1);
    send_bits(32'h5A, 8);
    repeat (4) @(negedge clk_in);
    cs = 1'b1;
    check_outcome("midrst", 0);
    repeat (4) @(negedge clk_in);
    frame("after_rst_1234", 32'h1234, 16);

    // Wrap-around from a clean counter
    do_reset(3);
    repeat (10) @(negedge clk_in);
    begin
      int v0;
      v0 = v_seen;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk_in);
        cs = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(32'(i), 16);
        repeat (4) @(negedge clk_in);
        cs = 1'b1;
        model_frame(32'(i), 16);
        repeat (12) @(negedge clk_in);
      end
      check("wrap_pulses", v_seen - v0, 256);
    end
    check("wrap_frame_count", frame_count, m_count);
    check("wrap_count_zero", frame_count, 0);
    check("wrap_data_out", data_out, 32'h00FF);
    check("wrap_err_cnt", e_seen, m_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 16, giving the number of bits in one frame.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sck, mosi and cs.
REQ-003 The block SHALL have port clk_in  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port sck  input  1  SPI serial clock; asynchronous to clk_in; idles low (mode 0).
REQ-006 The block SHALL have port mosi  input  1  SPI serial data; MSB first.
REQ-007 The block SHALL have port cs  input  1  SPI chip select; active-low; asynchronous to clk_in.
REQ-008 The block SHALL have port data_out  output  FRAME_BITS  last accepted frame word.
REQ-009 The block SHALL have port data_valid  output  1  one-cycle pulse marking a newly accepted frame.
REQ-010 The block SHALL have port frame_err  output  1  one-cycle pulse marking a rejected frame (wrong bit count).
REQ-011 The block SHALL have port busy  output  1  high while a frame is being received.
REQ-012 The block SHALL have port frame_count  output  8  count of accepted frames; wraps at 255.

Function
REQ-013 sck, mosi and cs SHALL each pass through SYNC_STAGES flops plus one history flop; edges SHALL be detected on the synchronized values only.
REQ-014 mosi and sck SHALL use identical synchronizer depth, so the mosi sample stays aligned with its sck edge.
REQ-015 The state machine SHALL have states WAIT_IDLE, IDLE, SHIFT and END.
- WAIT_IDLE: entered after reset; moves to IDLE on the first cycle with synchronized cs high.
- IDLE: moves to SHIFT on a synchronized cs falling edge.
- SHIFT: moves to END on a synchronized cs rising edge.
- END: evaluates the frame for one cycle, then returns to IDLE.
REQ-016 In SHIFT, each synchronized sck rising edge SHALL shift the synchronized mosi into the LSB of the shift register and increment the bit counter.
REQ-017 The bit counter SHALL saturate at FRAME_BITS+1.
REQ-018 In states other than SHIFT, sck edges SHALL be ignored.
REQ-019 If an sck rising edge and a cs rising edge are detected in the same cycle, the bit SHALL be captured and counted before the frame is evaluated.
REQ-020 In END, if the bit count equals FRAME_BITS, the block SHALL:
- load data_out from the shift register;
- pulse data_valid;
- increment frame_count modulo 256.
REQ-021 In END, if the bit count differs from FRAME_BITS (including zero), the block SHALL pulse frame_err and leave data_out and frame_count unchanged.
REQ-022 data_valid and frame_err SHALL rise on the clk_in edge SYNC_STAGES+2 edges after the first clk_in edge that samples cs high.
REQ-023 data_valid and frame_err SHALL each be high for exactly one cycle and SHALL never be high together.
REQ-024 busy SHALL be high in SHIFT and END and low otherwise.
REQ-025 The bit counter and shift register SHALL clear on entry to SHIFT.
REQ-026 Correct operation SHALL require the clk_in frequency to be at least 4x the sck frequency, and the sck high and low times each to be at least 2 clk_in periods.

Reset
REQ-027 With rst high at a clk_in edge, the block SHALL:
- enter WAIT_IDLE;
- drive data_out=0, data_valid=0, frame_err=0, busy=0 and frame_count=0;
- clear the shift register, bit counter and synchronizers (cs synchronizer to 1).
REQ-028 A reset asserted mid-frame SHALL abort the frame and produce no data_valid or frame_err.
REQ-029 Bits arriving after reset while cs stays low SHALL be discarded until cs has been seen high.

Verification
REQ-030 Reset check: assert rst for 3 cycles -> data_out=0x0000, frame_count=0, busy=0, no data_valid or frame_err pulses.
REQ-031 Good frame: cs low, send 0xA5C3 in 16 sck cycles (sck = clk_in/8), cs high -> exactly one data_valid pulse at the REQ-022 latency, data_out=0xA5C3, frame_count=1.
REQ-032 Short and long frames: send 15 bits, then send 17 bits -> one frame_err pulse each, data_out stays 0xA5C3, frame_count stays 1.
REQ-033 Empty frame: cs low for 10 cycles with no sck -> one frame_err pulse; busy high from the cs fall until END.
REQ-034 Wrap-around: send 256 good frames with values 0x0000 to 0x00FF -> frame_count returns to 0, last data_out=0x00FF, 256 data_valid pulses.
REQ-035 Reset mid-frame: rst pulsed after 8 bits with cs held low, 8 more bits sent, then cs high -> no data_valid or frame_err; the next 0x1234 frame gives data_out=0x1234 and frame_count=1.
